fetch_align: RTL



---
 rtl/fetch_align.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// RV32IC instruction-fetch stage: word fetch from 1-cycle imem, halfword realignment,
// one pc/instruction pair per cycle to decode, with stall and redirect handling.
module fetch_align #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_compressed_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_ERR} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, r_fetch_addr;
  logic [15:0] r_h;
  logic        r_h_vld;
  logic [31:0] r_w;
  logic        r_w_vld;
  logic        r_outst;
  logic        r_id_valid, r_id_comp;
  logic [31:0] r_id_pc, r_id_instr;

  logic        w_resp, w_weff_vld, w_active, w_w_keep;
  logic [31:0] w_weff;
  logic        w_emit, w_comp, w_consume, w_h_vld_nx;
  logic [31:0] w_instr, w_pc_inc;
  logic [15:0] w_h_nx;
  logic        w_req;
  logic [31:0] w_addr;

  // A response is present exactly one cycle after a request; W bypasses it when empty.
  assign w_resp     = r_outst;
  assign w_weff_vld = r_w_vld | w_resp;
  assign w_weff     = r_w_vld ? r_w : imem_rdata_i;
  assign w_active   = (r_state == S_RUN) && !stall_i && !redirect_i;
  assign w_w_keep   = w_weff_vld && !w_consume;

  always_comb begin
    w_emit     = 1'b0;
    w_comp     = 1'b0;
    w_instr    = NOP_INSTR;
    w_pc_inc   = 32'd0;
    w_consume  = 1'b0;
    w_h_nx     = r_h;
    w_h_vld_nx = r_h_vld;
    if (w_active) begin
      if (r_h_vld && (r_h[1:0] != 2'b11)) begin
        w_emit     = 1'b1;
        w_comp     = 1'b1;
        w_instr    = {16'h0000, r_h};
        w_pc_inc   = 32'd2;
        w_h_vld_nx = 1'b0;
      end else if (r_h_vld && w_weff_vld) begin
        w_emit    = 1'b1;
        w_instr   = {w_weff[15:0], r_h};
        w_pc_inc  = 32'd4;
        w_h_nx    = w_weff[31:16];
        w_consume = 1'b1;
      end else if (!r_h_vld && w_weff_vld) begin
        w_consume = 1'b1;
        w_h_nx    = w_weff[31:16];
        if (r_pc[1]) begin
          // odd-halfword entry point: only the upper parcel belongs to the stream
          w_h_vld_nx = 1'b1;
        end else if (w_weff[1:0] != 2'b11) begin
          w_emit     = 1'b1;
          w_comp     = 1'b1;
          w_instr    = {16'h0000, w_weff[15:0]};
          w_pc_inc   = 32'd2;
          w_h_vld_nx = 1'b1;
        end else begin
          w_emit   = 1'b1;
          w_instr  = w_weff;
          w_pc_inc = 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (redirect_i) begin
      w_state_nx = redirect_pc_i[0] ? S_ERR : S_RUN;
    end else begin
      case (r_state)
        S_BOOT:  if (!stall_i) w_state_nx = S_RUN;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_comb begin
    w_req  = 1'b0;
    w_addr = r_fetch_addr;
    if (!rst) begin
      if (redirect_i) begin
        w_req  = !redirect_pc_i[0];
        w_addr = {redirect_pc_i[31:2], 2'b00};
      end else begin
        case (r_state)
          S_BOOT:  w_req = !stall_i;
          S_RUN:   w_req = !stall_i && !w_w_keep;
          default: w_req = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_h_vld      <= 1'b0;
      r_w_vld      <= 1'b0;
      r_outst      <= 1'b0;
      r_id_valid   <= 1'b0;
      r_id_pc      <= RESET_PC;
      r_id_instr   <= NOP_INSTR;
      r_id_comp    <= 1'b0;
    end else begin
      r_outst <= w_req;
      if (w_req) r_fetch_addr <= w_addr + 32'd4;
      if (redirect_i) begin
        r_pc    <= redirect_pc_i;
        r_h_vld <= 1'b0;
        r_w_vld <= 1'b0;
      end else begin
        r_pc    <= r_pc + w_pc_inc;
        r_h     <= w_h_nx;
        r_h_vld <= w_h_vld_nx;
        r_w_vld <= w_w_keep;
        if (!r_w_vld && w_resp) r_w <= imem_rdata_i;
      end
      if (redirect_i || !stall_i) begin
        r_id_valid <= w_emit;
        r_id_pc    <= w_emit ? r_pc : r_id_pc;
        r_id_instr <= w_instr;
        r_id_comp  <= w_comp;
      end
    end
  end

  assign imem_req_o      = w_req;
  assign imem_addr_o     = w_addr;
  assign id_valid_o      = r_id_valid;
  assign id_pc_o         = r_id_pc;
  assign id_instr_o      = r_id_instr;
  assign id_compressed_o = r_id_comp;
  assign fetch_err_o     = (r_state == S_ERR);

endmodule
